// File: rtl/load_store_queue_pkg.sv
// Shared types for the load/store queue: decoded op, CDB slots,
// queue entry, FSM state and CDB snoop helpers.
package load_store_queue_pkg;

  localparam int LSQ_ENTRIES     = 8;
  localparam int ROB_TAG_W       = 3;
  localparam int NUM_CDB_ENTRIES = 2;
  localparam int PTR_W           = $clog2(LSQ_ENTRIES);
  localparam int CNT_W           = PTR_W + 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef enum logic {
    op_load  = 1'b0,
    op_store = 1'b1
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } i_decode_opcode_t;

  typedef struct packed {
    rob_tag_t    tag;
    logic [31:0] val;
  } cdb_entry_t;

  typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

  typedef struct packed {
    logic        valid;
    op_e         op;
    logic [2:0]  funct3;
    rob_tag_t    tag;
    logic [31:0] rs1_val;
    rob_tag_t    rs1_tag;
    logic [31:0] rs2_val;
    rob_tag_t    rs2_tag;
    logic [31:0] imm;
  } lsq_entry_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } lsq_state_e;

  // Tag 0 means "ready" and never matches an idle slot.
  function automatic logic cdb_hit(cdb_t c, rob_tag_t t);
    cdb_hit = 1'b0;
    for (int i = 0; i < NUM_CDB_ENTRIES; i++)
      if (t != '0 && c[i].tag == t) cdb_hit = 1'b1;
  endfunction

  function automatic logic [31:0] cdb_val(cdb_t c, rob_tag_t t);
    cdb_val = '0;
    for (int i = 0; i < NUM_CDB_ENTRIES; i++)
      if (t != '0 && c[i].tag == t) cdb_val = c[i].val;
  endfunction

endpackage

// File: rtl/lsq_data_align.sv
// Byte-lane alignment: store mbe/wdata generation and load extraction.
// Ports: funct3_i, off_i (addr[1:0]), wdata_i, rdata_i -> mbe_o, wdata_o, ld_o.
import load_store_queue_pkg::*;

module lsq_data_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mbe_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_o
);

  logic [31:0] lane;

  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    mbe_o   = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        mbe_o   = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        mbe_o   = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_o = rdata_i;
    case (funct3_i)
      F3_B:  ld_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:  ld_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU: ld_o = {24'h0, lane[7:0]};
      F3_HU: ld_o = {16'h0, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue between dispatch and the data-memory port.
// Ports: dispatch (load_lsq, instr_i, tags/vals), cdb snoop, ROB head, memory bus, lsq_cdb_o.
import load_store_queue_pkg::*;

module load_store_queue (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load_lsq,
  input  i_decode_opcode_t instr_i,
  input  rob_tag_t         rob_tag_i,
  input  logic [31:0]      rs1_val_i,
  input  rob_tag_t         rs1_tag_i,
  input  logic [31:0]      rs2_val_i,
  input  rob_tag_t         rs2_tag_i,
  input  cdb_t             cdb,
  input  rob_tag_t         rob_head_ptr,
  input  logic             rob_curr_is_store,
  output logic             rob_store_complete,
  output cdb_entry_t       lsq_cdb_o,
  output logic             full,
  output logic             data_read,
  output logic             data_write,
  output logic [3:0]       data_mbe,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic [31:0]      data_rdata,
  input  logic             data_resp
);

  lsq_entry_t [LSQ_ENTRIES-1:0] entries_q, entries_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  lsq_state_e       state_q;

  logic        rd_q, wr_q, cmp_q;
  logic [3:0]  mbe_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  off_q;
  cdb_entry_t  cdb_q;

  lsq_entry_t  new_e, head_e;
  logic        enq, pop, can_issue;
  logic [31:0] addr_d, wdata_d, ld_val;
  logic [3:0]  mbe_d;
  logic [1:0]  off;

  assign full   = (count_q == CNT_W'(LSQ_ENTRIES));
  assign enq    = load_lsq && !full;
  assign pop    = (state_q == MEM_WAIT) && data_resp;
  assign head_e = entries_q[head_q];
  assign addr_d = head_e.rs1_val + head_e.imm;

  // Stores wait until the ROB says they are the oldest instruction.
  assign can_issue = head_e.valid && head_e.rs1_tag == '0 &&
    (head_e.op == op_load ||
     (head_e.rs2_tag == '0 && rob_curr_is_store &&
      rob_head_ptr == head_e.tag));

  // The head is stable in MEM_WAIT, so only the offset needs holding.
  assign off = (state_q == IDLE) ? addr_d[1:0] : off_q;

  lsq_data_align u_align (
    .funct3_i (head_e.funct3),
    .off_i    (off),
    .wdata_i  (head_e.rs2_val),
    .rdata_i  (data_rdata),
    .mbe_o    (mbe_d),
    .wdata_o  (wdata_d),
    .ld_o     (ld_val)
  );

  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.op      = instr_i.op;
    new_e.funct3  = instr_i.funct3;
    new_e.imm     = instr_i.imm;
    new_e.tag     = rob_tag_i;
    new_e.rs1_val = rs1_val_i;
    new_e.rs1_tag = rs1_tag_i;
    new_e.rs2_val = rs2_val_i;
    new_e.rs2_tag = rs2_tag_i;
    if (cdb_hit(cdb, rs1_tag_i)) begin
      new_e.rs1_val = cdb_val(cdb, rs1_tag_i);
      new_e.rs1_tag = '0;
    end
    if (cdb_hit(cdb, rs2_tag_i)) begin
      new_e.rs2_val = cdb_val(cdb, rs2_tag_i);
      new_e.rs2_tag = '0;
    end
  end

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < LSQ_ENTRIES; i++) begin
      if (entries_q[i].valid) begin
        if (cdb_hit(cdb, entries_q[i].rs1_tag)) begin
          entries_d[i].rs1_val = cdb_val(cdb, entries_q[i].rs1_tag);
          entries_d[i].rs1_tag = '0;
        end
        if (cdb_hit(cdb, entries_q[i].rs2_tag)) begin
          entries_d[i].rs2_val = cdb_val(cdb, entries_q[i].rs2_tag);
          entries_d[i].rs2_tag = '0;
        end
      end
    end
    if (pop) entries_d[head_q].valid = 1'b0;
    if (enq) entries_d[tail_q] = new_e;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      mbe_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      cdb_q     <= '0;
      cmp_q     <= 1'b0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_q + CNT_W'(enq) - CNT_W'(pop);
      cdb_q     <= '0;
      cmp_q     <= 1'b0;
      if (enq) tail_q <= tail_q + PTR_W'(1);
      unique case (state_q)
        IDLE: begin
          if (can_issue) begin
            rd_q    <= (head_e.op == op_load);
            wr_q    <= (head_e.op == op_store);
            addr_q  <= {addr_d[31:2], 2'b00};
            mbe_q   <= mbe_d;
            wdata_q <= wdata_d;
            off_q   <= addr_d[1:0];
            state_q <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (data_resp) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            head_q  <= head_q + PTR_W'(1);
            state_q <= IDLE;
            if (head_e.op == op_load) begin
              cdb_q.tag <= head_e.tag;
              cdb_q.val <= ld_val;
            end else begin
              cmp_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign data_read          = rd_q;
  assign data_write         = wr_q;
  assign data_mbe           = mbe_q;
  assign data_addr          = addr_q;
  assign data_wdata         = wdata_q;
  assign lsq_cdb_o          = cdb_q;
  assign rob_store_complete = cmp_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: loads, stores, snoop,
// bypass, full/wrap and flush, with hand-computed expectations.
import load_store_queue_pkg::*;

module tb_load_store_queue;

  logic             clk = 1'b0;
  logic             rst, flush, load_lsq;
  i_decode_opcode_t instr;
  rob_tag_t         rob_tag, rs1_tag, rs2_tag, rob_head_ptr;
  logic [31:0]      rs1_val, rs2_val;
  cdb_t             cdb_s;
  logic             rob_curr_is_store;
  logic             rob_store_complete;
  cdb_entry_t       lsq_cdb;
  logic             full, data_read, data_write;
  logic [3:0]       data_mbe;
  logic [31:0]      data_addr, data_wdata, data_rdata;
  logic             data_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_queue dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .load_lsq           (load_lsq),
    .instr_i            (instr),
    .rob_tag_i          (rob_tag),
    .rs1_val_i          (rs1_val),
    .rs1_tag_i          (rs1_tag),
    .rs2_val_i          (rs2_val),
    .rs2_tag_i          (rs2_tag),
    .cdb                (cdb_s),
    .rob_head_ptr       (rob_head_ptr),
    .rob_curr_is_store  (rob_curr_is_store),
    .rob_store_complete (rob_store_complete),
    .lsq_cdb_o          (lsq_cdb),
    .full               (full),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_mbe           (data_mbe),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .data_rdata         (data_rdata),
    .data_resp          (data_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input op_e op, input logic [2:0] f3,
                     input logic [31:0] imm, input rob_tag_t tag,
                     input logic [31:0] r1v, input rob_tag_t r1t,
                     input logic [31:0] r2v, input rob_tag_t r2t);
    instr.op     = op;
    instr.funct3 = f3;
    instr.imm    = imm;
    rob_tag      = tag;
    rs1_val      = r1v;
    rs1_tag      = r1t;
    rs2_val      = r2v;
    rs2_tag      = r2t;
    load_lsq     = 1'b1;
    tick();
    load_lsq     = 1'b0;
  endtask

  task automatic resp(input logic [31:0] v);
    data_rdata = v;
    data_resp  = 1'b1;
    tick();
    data_resp  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; load_lsq = 1'b0;
    instr = '0; rob_tag = '0; rs1_tag = '0; rs2_tag = '0;
    rs1_val = '0; rs2_val = '0; cdb_s = '0;
    rob_head_ptr = '0; rob_curr_is_store = 1'b0;
    data_rdata = '0; data_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_full", full, 0);
    check("rst_rd", data_read, 0);
    check("rst_wr", data_write, 0);
    check("rst_mbe", data_mbe, 0);
    check("rst_addr", data_addr, 0);
    check("rst_cdb", lsq_cdb, 0);
    check("rst_cmp", rob_store_complete, 0);

    // lw tag 3 at 0x1000+4
    enq(op_load, F3_W, 32'd4, 3'd3, 32'h1000, '0, '0, '0);
    check("lw_no_same_cycle", data_read, 0);
    tick();
    check("lw_rd", data_read, 1);
    check("lw_addr", data_addr, 32'h1004);
    check("lw_mbe", data_mbe, 4'b1111);
    tick();
    check("lw_hold", data_read, 1);
    resp(32'hDEADBEEF);
    check("lw_rd_drop", data_read, 0);
    check("lw_cdb", lsq_cdb, {3'd3, 32'hDEADBEEF});
    tick();
    check("lw_cdb_once", lsq_cdb, 0);

    // lb / lbu at 0x1003
    enq(op_load, F3_B, 32'd3, 3'd1, 32'h1000, '0, '0, '0);
    tick();
    check("lb_addr", data_addr, 32'h1000);
    check("lb_mbe", data_mbe, 4'b1000);
    resp(32'h80000000);
    check("lb_cdb", lsq_cdb, {3'd1, 32'hFFFFFF80});
    enq(op_load, F3_BU, 32'd3, 3'd2, 32'h1000, '0, '0, '0);
    tick();
    resp(32'h80000000);
    check("lbu_cdb", lsq_cdb, {3'd2, 32'h00000080});

    // sh gated by ROB head
    rob_head_ptr = 3'd4;
    rob_curr_is_store = 1'b1;
    enq(op_store, F3_H, 32'd2, 3'd5, 32'h2000, '0, 32'h1234, '0);
    tick(); tick();
    check("st_gated", data_write, 0);
    rob_head_ptr = 3'd5;
    tick();
    check("st_wr", data_write, 1);
    check("st_rd", data_read, 0);
    check("st_addr", data_addr, 32'h2000);
    check("st_mbe", data_mbe, 4'b1100);
    check("st_wdata", data_wdata, 32'h12341234);
    check("st_no_cmp_early", rob_store_complete, 0);
    resp(32'h0);
    check("st_wr_drop", data_write, 0);
    check("st_cmp", rob_store_complete, 1);
    check("st_no_cdb", lsq_cdb, 0);
    tick();
    check("st_cmp_once", rob_store_complete, 0);
    rob_curr_is_store = 1'b0;

    // same-cycle CDB bypass on enqueue
    cdb_s[0].tag = 3'd2;
    cdb_s[0].val = 32'h3000;
    enq(op_load, F3_W, 32'd0, 3'd6, 32'h0, 3'd2, '0, '0);
    cdb_s = '0;
    tick();
    check("byp_rd", data_read, 1);
    check("byp_addr", data_addr, 32'h3000);
    resp(32'h55);
    check("byp_cdb", lsq_cdb, {3'd6, 32'h55});

    // snoop after enqueue
    enq(op_load, F3_W, 32'd8, 3'd7, 32'h0, 3'd4, '0, '0);
    tick();
    check("snp_wait", data_read, 0);
    cdb_s[1].tag = 3'd4;
    cdb_s[1].val = 32'h4000;
    tick();
    cdb_s = '0;
    check("snp_not_yet", data_read, 0);
    tick();
    check("snp_rd", data_read, 1);
    check("snp_addr", data_addr, 32'h4008);
    resp(32'h66);
    check("snp_cdb", lsq_cdb, {3'd7, 32'h66});

    // fill, ignore 9th, drain in order across the wrap
    for (int k = 0; k < 8; k++)
      enq(op_load, F3_W, 32'd0, rob_tag_t'(k % 7 + 1),
          32'h100 * (k + 1), '0, '0, '0);
    check("fill_full", full, 1);
    enq(op_load, F3_W, 32'd0, 3'd7, 32'h9900, '0, '0, '0);
    check("fill_still_full", full, 1);
    for (int k = 0; k < 8; k++) begin
      if (!data_read) tick();
      check("drain_rd", data_read, 1);
      check("drain_addr", data_addr, 32'h100 * (k + 1));
      resp(32'hA0 + k);
      check("drain_cdb", lsq_cdb,
            {rob_tag_t'(k % 7 + 1), 32'hA0 + k});
    end
    check("drain_not_full", full, 0);
    tick();
    check("ninth_ignored", data_read, 0);
    enq(op_load, F3_W, 32'd0, 3'd2, 32'hABC0, '0, '0, '0);
    tick();
    check("wrap_addr", data_addr, 32'hABC0);
    resp(32'h1);
    check("wrap_cdb", lsq_cdb, {3'd2, 32'h1});

    // flush in MEM_WAIT
    enq(op_load, F3_W, 32'd0, 3'd1, 32'h7000, '0, '0, '0);
    tick();
    check("fl_rd", data_read, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_rd_drop", data_read, 0);
    check("fl_addr", data_addr, 0);
    check("fl_full", full, 0);
    resp(32'hBAD);
    check("fl_late_resp", lsq_cdb, 0);
    tick();
    check("fl_no_cdb", lsq_cdb, 0);
    check("fl_empty", data_read, 0);
    enq(op_load, F3_HU, 32'd2, 3'd3, 32'h8000, '0, '0, '0);
    tick();
    check("post_fl_addr", data_addr, 32'h8000);
    check("post_fl_mbe", data_mbe, 4'b1100);
    resp(32'h8001_0000);
    check("post_fl_lhu", lsq_cdb, {3'd3, 32'h00008001});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
- In-order load/store queue between the decoder/dispatch stage and the data-memory port.
- Works alongside the reorder buffer. Loads and stores are enqueued at dispatch with their ROB tag, and their operands are captured from the CDB.
- Loads issue to memory as soon as they reach the queue head with a ready address. The result is broadcast on the LSQ's CDB slot.
- Stores issue only when the ROB head is that store. Completion is signalled to the ROB with a one-cycle pulse.

Parameters:
- LSQ_ENTRIES, 8, queue depth (power of two).
- ROB_TAG_W, 3, width of a ROB tag (clog2 of RO_BUFFER_ENTRIES). Tag 0 is reserved and means "value ready".

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  ROB mispredict flush; clears the queue.
- load_lsq  in  1  enqueue strobe from the decoder.
- instr_i  in  i_decode_opcode_t  opcode (op_load/op_store), funct3, immediate.
- rob_tag_i  in  ROB_TAG_W  ROB tag of the instruction.
- rs1_val_i / rs1_tag_i  in  32 / ROB_TAG_W  base address operand; tag 0 means the value is valid.
- rs2_val_i / rs2_tag_i  in  32 / ROB_TAG_W  store-data operand, same convention.
- cdb  in  cdb_t  all NUM_CDB_ENTRIES broadcast slots (tag, value).
- rob_head_ptr  in  ROB_TAG_W  current ROB head tag.
- rob_curr_is_store  in  1  ROB head is a store.
- rob_store_complete  out  1  one-cycle pulse when the head store's write is acknowledged.
- lsq_cdb_o  out  cdb entry  load result; tag 0 means idle.
- full  out  1  no free entry.
- data_read, data_write  out  1  memory strobes.
- data_mbe  out  4  byte enables.
- data_addr  out  32  word-aligned address.
- data_wdata  out  32  lane-shifted store data.
- data_rdata  in  32  read data.
- data_resp  in  1  memory acknowledge.

Behaviour:
- Reset is synchronous and active-high. Reset or flush clears all entries, head = tail = 0, count = 0, state = IDLE. All outputs go to 0: strobes, mbe, addr, wdata, rob_store_complete and lsq_cdb_o.
- Circular FIFO with head/tail of width clog2(LSQ_ENTRIES) that wrap naturally, and a count of width clog2+1.
- full = (count == LSQ_ENTRIES).
- A load_lsq asserted while full is ignored. The decoder must not do this.
- Enqueue writes the entry with valid=1, stored operands and tags. An operand whose tag matches any CDB slot in the same cycle is captured as ready with the broadcast value (bypass).
- Snoop: every cycle, each valid entry with a nonzero rs1/rs2 tag that matches a CDB slot takes that value and clears the tag.
- FSM IDLE:
  - If the head entry is valid with rs1 ready, compute addr = rs1 + imm (32-bit wrap).
  - Load: issue immediately.
  - Store: issue only when rs2 is ready AND rob_head_ptr == entry tag AND rob_curr_is_store.
  - On issue, register data_read or data_write, data_addr = {addr[31:2], 2'b00}, mbe and wdata, then go to MEM_WAIT.
- mbe and wdata by funct3:
  - sb: mbe = 0001 << addr[1:0], byte replicated into all lanes.
  - sh: mbe = 0011 << addr[1:0], half replicated.
  - sw: mbe = 1111, data unshifted.
- Misaligned halfword/word accesses are not supported; behaviour is undefined.
- MEM_WAIT: hold all memory outputs stable until data_resp. On data_resp: deassert the strobes, pop the head, count-1, return to IDLE.
  - Load: on the next cycle, lsq_cdb_o = {rob tag, extracted value} for exactly one cycle.
  - Load extraction: lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified; the lane is selected by addr[1:0].
  - Store: rob_store_complete = 1 for exactly one cycle.
- Latency: earliest issue is the cycle after the entry becomes head-ready.
- Back-to-back: the next issue may occur the cycle after returning to IDLE.
- Simultaneous enqueue and pop leaves count unchanged. Enqueue into an empty queue cannot issue in the same cycle.
- Flush mid-MEM_WAIT: strobes drop immediately and any late data_resp is ignored. The memory model must tolerate an aborted request.

Decomposition:
- structs package: lsq_entry_t (valid, op, tag, rs1/rs2 val+tag, imm) and lsq_state_e {IDLE, MEM_WAIT}.
- Macro `LSQ_ENTRIES belongs in macros.sv.
- One sub-module, lsq_data_align: combinational mbe/wdata generation and load extraction/extension. It is tested standalone.

Test Plan:
- Load, ready operand: rs1=0x1000, imm=4, lw, tag 3, rdata=0xDEADBEEF. Expect data_read at addr 0x1004, mbe=1111, then lsq_cdb_o={3,0xDEADBEEF} for 1 cycle.
- Sign-extension: lb at 0x1003 with rdata=0x80000000 gives 0xFFFFFF80. lbu gives 0x00000080.
- Store gating: sh, tag 5, addr 0x2002, data 0x1234, rob_head_ptr=4. No write occurs. When rob_head_ptr becomes 5 with rob_curr_is_store=1, expect a write with mbe=1100, wdata=0x12341234, then rob_store_complete pulses once after data_resp.
- CDB snoop/bypass: enqueue a load with rs1_tag=2 while the CDB broadcasts {2,0x3000} in the same cycle. Expect issue at 0x3000 with no stall.
- Full/wrap: fill 8 entries, so full=1 and a 9th enqueue is ignored. Drain all 8 with resp, then enqueue again. Head wraps and the order is preserved.
- Flush in MEM_WAIT: assert flush and expect strobes=0 and count=0 next cycle, a late data_resp producing no CDB output, and full=0.
